column_accumulator: RTL and testbench
=====================================

Name: column_accumulator

Overview:
- Writer side of the unified-buffer store path, one instance per systolic-array column (acc1, acc2).
- Captures the 8-bit results leaving the bottom of its column into a DEPTH-entry buffer. In accumulate mode it adds each result to the value already held.
- Presents the entries and a full flag to the unified buffer, holding them until the buffer's store strobe drains them.

Parameters:
- DATA_W, 8, entry/result width; results are signed two's complement.
- DEPTH, 2, entries per column (one per array row); only DEPTH=2 is exercised in the top level.
- PTR_W, 1, write-pointer width; must satisfy 2**PTR_W >= DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  column output valid this cycle.
- data_in  in  DATA_W  column output value.
- accumulate  in  1  1: entry <= entry + data_in; 0: entry <= data_in. Sampled together with valid_in.
- clear  in  1  zero all entries and return to EMPTY.
- store  in  1  drain strobe; the same signal that drives the unified buffer's store input.
- full  out  1  all DEPTH entries written; drives the buffer's store_acc flag.
- acc_mem_0  out  DATA_W  entry 0.
- acc_mem_1  out  DATA_W  entry 1.
- overrun  out  1  one-cycle pulse when valid_in is dropped.

Behaviour:
- Reset values (reset has priority over every other input):
  - state=EMPTY, wr_ptr=0.
  - All entries=0, so acc_mem_0=acc_mem_1=0.
  - full=0, overrun=0.
- Outputs are registered and update one cycle after the sampling edge.
- acc_mem_* always reflect the entry registers, in every state.
- States:
  - EMPTY: wr_ptr=0, full=0.
  - FILLING: 0<wr_ptr<DEPTH, full=0.
  - FULL: full=1.
- Accepted write:
  - A write is accepted when valid_in=1 and the state is not FULL.
  - Entry[wr_ptr] gets data_in (accumulate=0) or entry[wr_ptr]+data_in (accumulate=1); wr_ptr increments.
  - EMPTY goes to FILLING.
  - When wr_ptr reaches DEPTH: next state FULL, wr_ptr wraps to 0, full=1 from the following cycle.
- store:
  - Acts only when state==FULL.
  - FULL -> EMPTY; full=0 the next cycle.
  - Entries are NOT cleared, which allows multi-pass accumulation across tiles.
  - store in EMPTY or FILLING is ignored.
- store and valid_in in the same cycle while FULL:
  - The drain happens, and the incoming sample is written to entry 0 of the new tile.
  - Next state is FILLING with wr_ptr=1.
  - The buffer still captures the pre-edge entry values.
- valid_in in FULL without store:
  - The sample is dropped and entries are unchanged.
  - overrun pulses high for exactly one cycle.
- clear:
  - Zeroes all entries; wr_ptr=0; state EMPTY.
  - Beats store and valid_in in the same cycle; no overrun is raised.
- Arithmetic:
  - The add is performed at DATA_W+1 bits.
  - Without the optional feature the result wraps modulo 2**DATA_W.
- Reset asserted mid-tile discards the partial tile; there is no recovery.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: accumulate adds saturate to the signed range. Positive overflow gives 8'h7F, negative overflow gives 8'h80. An added output sat_flag (1 bit) is sticky: it is set on any saturation and cleared by reset or clear.
- Undefined: adds wrap, and the sat_flag port does not exist.

Decomposition:
- Package tpu_pkg holds:
  - DATA_W_DEFAULT.
  - The state typedef acc_state_t {ACC_EMPTY, ACC_FILLING, ACC_FULL}.
  - Saturation constants SAT_MAX=8'h7F and SAT_MIN=8'h80.
- One natural sub-module, acc_adder: combinational add/pass-through, with saturation under ACC_SATURATE_EN.
- The state machine and entry registers stay in column_accumulator.

Test Plan:
- Basic fill and drain:
  - Reset, then valid_in with 5 and then 9, accumulate=0.
  - Required: full=1 with acc_mem_0=5, acc_mem_1=9. store for one cycle gives full=0 next cycle, entries still 5 and 9.
- Multi-pass accumulation:
  - After the tile above, send valid_in 3 then -2 with accumulate=1.
  - Required: acc_mem_0=8, acc_mem_1=7, full=1.
- Overrun:
  - While FULL, valid_in=1 with data 42 and no store.
  - Required: overrun=1 for one cycle, entries unchanged, full stays 1.
- Drain and write in the same cycle:
  - While FULL (entries 5 and 9), store=1 and valid_in=1 with data 11, accumulate=0.
  - Required: full=0, acc_mem_0=11, acc_mem_1=9, wr_ptr=1. The next valid_in of 4 gives acc_mem_1=4 and full=1.
- Clear priority:
  - In FILLING, assert clear, valid_in (data 6) and store together.
  - Required: entries are 0, state EMPTY, full=0, overrun=0.
- Overflow:
  - Entry 100 plus accumulate of 100.
  - Required: entry wraps to 8'hC8 (-56). Under ACC_SATURATE_EN the entry is 8'h7F and sat_flag=1.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic-array store path.
package tpu_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ACC_EMPTY,
        ACC_FILLING,
        ACC_FULL
    } acc_state_t;

    localparam logic [DATA_W_DEFAULT-1:0] SAT_MAX = 8'h7F;
    localparam logic [DATA_W_DEFAULT-1:0] SAT_MIN = 8'h80;

endpackage

// File: rtl/column_accumulator_if.sv
// Column-to-unified-buffer bus: result stream and control in, entries and flags out.
// ACC_SATURATE_EN adds the sticky sat_flag output.
interface column_accumulator_if
    import tpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);
    logic                     valid_in;
    logic signed [DATA_W-1:0] data_in;
    logic                     accumulate;
    logic                     clear;
    logic                     store;
    logic                     full;
    logic signed [DATA_W-1:0] acc_mem_0;
    logic signed [DATA_W-1:0] acc_mem_1;
    logic                     overrun;
`ifdef ACC_SATURATE_EN
    logic                     sat_flag;
`endif

    modport master (
        output valid_in, data_in, accumulate, clear, store,
        input  full, acc_mem_0, acc_mem_1, overrun
`ifdef ACC_SATURATE_EN
        , sat_flag
`endif
    );

    modport slave (
        input  valid_in, data_in, accumulate, clear, store,
        output full, acc_mem_0, acc_mem_1, overrun
`ifdef ACC_SATURATE_EN
        , sat_flag
`endif
    );

endinterface

// File: rtl/column_accumulator_acc_adder.sv
// Combinational entry update: pass-through or (DATA_W+1)-bit add.
// ACC_SATURATE_EN clamps the add to the signed range instead of wrapping.
module acc_adder
    import tpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic signed [DATA_W-1:0] entry_i,
    input  logic signed [DATA_W-1:0] data_i,
    input  logic                     accumulate_i,
    output logic signed [DATA_W-1:0] result_o
`ifdef ACC_SATURATE_EN
    ,
    output logic                     sat_o
`endif
);

    logic [DATA_W:0] sum_wide;

    assign sum_wide = {entry_i[DATA_W-1], entry_i} + {data_i[DATA_W-1], data_i};

`ifdef ACC_SATURATE_EN
    // Overflow shows as the extra sign bit disagreeing with the result sign bit.
    always_comb begin
        result_o = data_i;
        sat_o    = 1'b0;
        if (accumulate_i) begin
            if (sum_wide[DATA_W] != sum_wide[DATA_W-1]) begin
                sat_o    = 1'b1;
                result_o = sum_wide[DATA_W] ? SAT_MIN : SAT_MAX;
            end else begin
                result_o = sum_wide[DATA_W-1:0];
            end
        end
    end
`else
    logic unused_sum_msb;
    assign unused_sum_msb = sum_wide[DATA_W];

    always_comb begin
        result_o = data_i;
        if (accumulate_i) begin
            result_o = sum_wide[DATA_W-1:0];
        end
    end
`endif

endmodule

// File: rtl/column_accumulator.sv
// Per-column result buffer feeding the unified buffer: fills DEPTH entries, holds them
// until store drains the tile. ACC_SATURATE_EN selects saturating accumulate + sat_flag.
module column_accumulator
    import tpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 2,
    parameter int PTR_W  = 1
) (
    input  logic               clk,
    input  logic               reset,
    column_accumulator_if.slave bus
);

    acc_state_t               state_q, state_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic signed [DATA_W-1:0] entry_q [DEPTH];
    logic signed [DATA_W-1:0] entry_d [DEPTH];
    logic                     full_q, full_d;
    logic                     overrun_q, overrun_d;
    logic signed [DATA_W-1:0] add_result;
    logic                     drain;
    logic                     accept;
`ifdef ACC_SATURATE_EN
    logic                     sat_q, sat_d;
    logic                     add_sat;
`endif

    // A FULL tile drained by store leaves wr_ptr at 0, so a same-cycle sample lands in entry 0.
    assign drain  = (state_q == ACC_FULL) && bus.store;
    assign accept = bus.valid_in && ((state_q != ACC_FULL) || bus.store);

    acc_adder #(
        .DATA_W (DATA_W)
    ) u_adder (
        .entry_i      (entry_q[wr_ptr_q]),
        .data_i       (bus.data_in),
        .accumulate_i (bus.accumulate),
        .result_o     (add_result)
`ifdef ACC_SATURATE_EN
        ,
        .sat_o        (add_sat)
`endif
    );

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        entry_d   = entry_q;
        overrun_d = 1'b0;
`ifdef ACC_SATURATE_EN
        sat_d     = sat_q;
`endif
        if (bus.clear) begin
            state_d  = ACC_EMPTY;
            wr_ptr_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i] = '0;
            end
`ifdef ACC_SATURATE_EN
            sat_d    = 1'b0;
`endif
        end else begin
            if (drain) begin
                state_d = ACC_EMPTY;
            end
            if (accept) begin
                entry_d[wr_ptr_q] = add_result;
                if (wr_ptr_q == PTR_W'(DEPTH - 1)) begin
                    state_d  = ACC_FULL;
                    wr_ptr_d = '0;
                end else begin
                    state_d  = ACC_FILLING;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
`ifdef ACC_SATURATE_EN
                sat_d = sat_q | add_sat;
`endif
            end else if (bus.valid_in) begin
                overrun_d = 1'b1;
            end
        end
        full_d = (state_d == ACC_FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ACC_EMPTY;
            wr_ptr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef ACC_SATURATE_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            entry_q   <= entry_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
`ifdef ACC_SATURATE_EN
            sat_q     <= sat_d;
`endif
        end
    end

    assign bus.full      = full_q;
    assign bus.acc_mem_0 = entry_q[0];
    assign bus.acc_mem_1 = entry_q[1];
    assign bus.overrun   = overrun_q;
`ifdef ACC_SATURATE_EN
    assign bus.sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_column_accumulator.sv
// Bench for column_accumulator: directed vector table, hand sequences, randomized model check.
module tb_column_accumulator;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    column_accumulator_if #(.DATA_W(8)) bus ();

    column_accumulator #(
        .DATA_W (8),
        .DEPTH  (2),
        .PTR_W  (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       a;
        logic       c;
        logic       s;
        logic       f;
        logic [7:0] m0;
        logic [7:0] m1;
        logic       o;
    } vec_t;

    vec_t tbl[$];

    // Reference model: tile contents, number of samples taken, and flags.
    int m_ent[2];
    int m_cnt;
    bit m_full;
    bit m_ovr;
    bit m_sat;

    function automatic vec_t mk(logic v, logic [7:0] d, logic a, logic c, logic s,
                                logic f, logic [7:0] m0, logic [7:0] m1, logic o);
        vec_t r;
        r.v = v; r.d = d; r.a = a; r.c = c; r.s = s;
        r.f = f; r.m0 = m0; r.m1 = m1; r.o = o;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int add_model(int a, int b);
        int s;
        s = a + b;
`ifdef ACC_SATURATE_EN
        if (s > 127) begin
            m_sat = 1'b1;
            return 127;
        end
        if (s < -128) begin
            m_sat = 1'b1;
            return -128;
        end
        return s;
`else
        s = s & 255;
        if (s > 127) s = s - 256;
        return s;
`endif
    endfunction

    task automatic model_reset();
        m_ent[0] = 0; m_ent[1] = 0;
        m_cnt = 0; m_full = 1'b0; m_ovr = 1'b0; m_sat = 1'b0;
    endtask

    task automatic model_step(bit v, int d, bit a, bit c, bit s);
        m_ovr = 1'b0;
        if (c) begin
            model_reset();
            return;
        end
        if (m_full && s) m_full = 1'b0;
        if (v) begin
            if (m_full) begin
                m_ovr = 1'b1;
            end else begin
                m_ent[m_cnt] = a ? add_model(m_ent[m_cnt], d) : d;
                m_cnt++;
                if (m_cnt == 2) begin
                    m_cnt  = 0;
                    m_full = 1'b1;
                end
            end
        end
    endtask

    task automatic apply(logic v, logic [7:0] d, logic a, logic c, logic s);
        bus.valid_in   = v;
        bus.data_in    = d;
        bus.accumulate = a;
        bus.clear      = c;
        bus.store      = s;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.clear    = 1'b0;
        bus.store    = 1'b0;
    endtask

    task automatic chk_out(input string tag, logic f, logic [7:0] m0, logic [7:0] m1, logic o);
        chk({tag, " full"},      int'(bus.full),      int'(f));
        chk({tag, " acc_mem_0"}, int'(bus.acc_mem_0), int'($signed(m0)));
        chk({tag, " acc_mem_1"}, int'(bus.acc_mem_1), int'($signed(m1)));
        chk({tag, " overrun"},   int'(bus.overrun),   int'(o));
    endtask

    initial begin
        logic [7:0] ovf_exp;
        checks = 0;
        errors = 0;
`ifdef ACC_SATURATE_EN
        ovf_exp = 8'h7F;
`else
        ovf_exp = 8'hC8;
`endif
        //           v  d      a  c  s   full m0     m1     ovr
        tbl.push_back(mk(1, 8'd5,   0, 0, 0,  0, 8'd5,   8'd0,  0)); // fill
        tbl.push_back(mk(1, 8'd9,   0, 0, 0,  1, 8'd5,   8'd9,  0));
        tbl.push_back(mk(0, 8'd0,   0, 0, 1,  0, 8'd5,   8'd9,  0)); // drain keeps entries
        tbl.push_back(mk(1, 8'd3,   1, 0, 0,  0, 8'd8,   8'd9,  0)); // multi-pass
        tbl.push_back(mk(1, 8'hFE,  1, 0, 0,  1, 8'd8,   8'd7,  0));
        tbl.push_back(mk(1, 8'd42,  0, 0, 0,  1, 8'd8,   8'd7,  1)); // overrun
        tbl.push_back(mk(0, 8'd0,   0, 0, 0,  1, 8'd8,   8'd7,  0)); // one-cycle pulse
        tbl.push_back(mk(0, 8'd0,   0, 0, 1,  0, 8'd8,   8'd7,  0));
        tbl.push_back(mk(1, 8'd5,   0, 0, 0,  0, 8'd5,   8'd7,  0));
        tbl.push_back(mk(1, 8'd9,   0, 0, 0,  1, 8'd5,   8'd9,  0));
        tbl.push_back(mk(1, 8'd11,  0, 0, 1,  0, 8'd11,  8'd9,  0)); // drain + write
        tbl.push_back(mk(1, 8'd4,   0, 0, 0,  1, 8'd11,  8'd4,  0));
        tbl.push_back(mk(0, 8'd0,   0, 0, 1,  0, 8'd11,  8'd4,  0));
        tbl.push_back(mk(1, 8'd1,   0, 0, 0,  0, 8'd1,   8'd4,  0)); // FILLING
        tbl.push_back(mk(1, 8'd6,   0, 1, 1,  0, 8'd0,   8'd0,  0)); // clear priority
        tbl.push_back(mk(1, 8'd2,   0, 0, 0,  0, 8'd2,   8'd0,  0)); // ptr back at 0
        tbl.push_back(mk(1, 8'd3,   0, 0, 0,  1, 8'd2,   8'd3,  0));
        tbl.push_back(mk(1, 8'd7,   0, 1, 0,  0, 8'd0,   8'd0,  0)); // clear in FULL, no overrun
        tbl.push_back(mk(1, 8'd100, 0, 0, 0,  0, 8'd100, 8'd0,  0));
        tbl.push_back(mk(1, 8'd5,   0, 0, 0,  1, 8'd100, 8'd5,  0));
        tbl.push_back(mk(0, 8'd0,   0, 0, 1,  0, 8'd100, 8'd5,  0));
        tbl.push_back(mk(1, 8'd100, 1, 0, 0,  0, ovf_exp, 8'd5, 0)); // overflow
        tbl.push_back(mk(0, 8'd0,   0, 0, 1,  0, ovf_exp, 8'd5, 0)); // store ignored in FILLING
        tbl.push_back(mk(1, 8'd10,  1, 0, 0,  1, ovf_exp, 8'd15, 0));

        bus.valid_in = 1'b0; bus.data_in = '0; bus.accumulate = 1'b0;
        bus.clear = 1'b0; bus.store = 1'b0;
        reset = 1'b1;

        // Reset dominates live inputs.
        apply(1'b1, 8'd77, 1'b0, 1'b0, 1'b1);
        apply(1'b1, 8'd77, 1'b0, 1'b0, 1'b1);
        chk_out("reset", 1'b0, 8'd0, 8'd0, 1'b0);
`ifdef ACC_SATURATE_EN
        chk("reset sat_flag", int'(bus.sat_flag), 0);
`endif
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].v, tbl[i].d, tbl[i].a, tbl[i].c, tbl[i].s);
            chk_out($sformatf("vec%0d", i), tbl[i].f, tbl[i].m0, tbl[i].m1, tbl[i].o);
        end

`ifdef ACC_SATURATE_EN
        chk("sat_flag sticky", int'(bus.sat_flag), 1);
        apply(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        chk("sat_flag clear", int'(bus.sat_flag), 0);
`else
        apply(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
`endif

        // Reset mid-tile discards the partial tile.
        apply(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        chk("midtile acc_mem_0", int'(bus.acc_mem_0), 3);
        reset = 1'b1;
        apply(1'b1, 8'd50, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk_out("midtile reset", 1'b0, 8'd0, 8'd0, 1'b0);
        apply(1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
        chk_out("after reset", 1'b0, 8'd7, 8'd0, 1'b0);
        apply(1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
        chk_out("after reset 2", 1'b1, 8'd7, 8'hF0, 1'b0);

        // Randomized run against the reference model.
        reset = 1'b1;
        apply(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            logic       rv, ra, rc, rs;
            logic [7:0] rd;
            rv = ($urandom_range(0, 9) < 6);
            ra = ($urandom_range(0, 1) == 1);
            rc = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 3) == 0);
            rd = 8'($urandom);
            model_step(rv, int'($signed(rd)), ra, rc, rs);
            apply(rv, rd, ra, rc, rs);
            chk("rand full",      int'(bus.full),      int'(m_full));
            chk("rand acc_mem_0", int'(bus.acc_mem_0), m_ent[0]);
            chk("rand acc_mem_1", int'(bus.acc_mem_1), m_ent[1]);
            chk("rand overrun",   int'(bus.overrun),   int'(m_ovr));
`ifdef ACC_SATURATE_EN
            chk("rand sat_flag",  int'(bus.sat_flag),  int'(m_sat));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
